// File: rtl/boron_pkg.sv
// rtl/boron_pkg.sv - BORON key schedule constants, FSM state type and S-box table
package boron_pkg;

  localparam int KEY_W      = 128;
  localparam int RK_W       = 64;
  localparam int NUM_ROUNDS = 25;
  localparam int IDX_W      = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Nibble i of this word is S(i): 0..F -> E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6
  localparam logic [63:0] SBOX_TABLE = 64'h6358F02DAC971B4E;

endpackage

// File: rtl/boron_key_update.sv
// rtl/boron_key_update.sv - combinational key register update f(k, c)
module boron_key_update
  import boron_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [IDX_W-1:0] cnt_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] rot;
  logic [3:0]       sb_hi;
  logic [3:0]       sb_lo;

  assign rot = {key_i[66:0], key_i[127:67]};

  boron_sbox u_sbox_hi (.x_i(rot[127:124]), .y_o(sb_hi));
  boron_sbox u_sbox_lo (.x_i(rot[123:120]), .y_o(sb_lo));

  assign key_o = {sb_hi, sb_lo, rot[119:67], rot[66:62] ^ cnt_i, rot[61:0]};

endmodule

// File: rtl/boron_sbox.sv
// rtl/boron_sbox.sv - BORON 4-bit S-box
module boron_sbox
  import boron_pkg::*;
(
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);

  assign y_o = SBOX_TABLE[{x_i, 2'b00} +: 4];

endmodule

// File: rtl/boron_key_sched_ctrl.sv
// rtl/boron_key_sched_ctrl.sv - BORON key schedule sequencer: key register, round counter, round key handshake
module boron_key_sched_ctrl
  import boron_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             abort,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [RK_W-1:0]  rk,
  output logic [IDX_W-1:0] rk_idx,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_inc;
  logic [KEY_W-1:0] key_next;

  assign idx_inc = idx_q + 5'd1;

  boron_key_update u_key_update (
    .key_i(key_q),
    .cnt_i(idx_inc),
    .key_o(key_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  // abort takes priority over a coincident handshake, leaving key and index untouched
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            key_d = key_next;
            idx_d = idx_inc;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rk_valid = (state_q == RUN);
  assign busy     = (state_q == LOAD) || (state_q == RUN);
  assign done     = (state_q == DONE);
  assign rk       = key_q[RK_W-1:0];
  assign rk_idx   = idx_q;

endmodule

// File: tb/tb_boron_key_sched_ctrl.sv
// tb/tb_boron_key_sched_ctrl.sv - self-checking bench for boron_key_sched_ctrl
module tb_boron_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_ready;
  logic         rk_valid;
  logic [63:0]  rk;
  logic [4:0]   rk_idx;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_rk [26];
  logic [63:0] cap_rk [26];

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [63:0]  rk;
  } vec_t;

  vec_t vecs [6];

  boron_key_sched_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key_in  (key_in),
    .abort   (abort),
    .rk_ready(rk_ready),
    .rk_valid(rk_valid),
    .rk      (rk),
    .rk_idx  (rk_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] tb_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hB;  4'h3: return 4'h1;
      4'h4: return 4'h7;  4'h5: return 4'h9;  4'h6: return 4'hC;  4'h7: return 4'hA;
      4'h8: return 4'hD;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'hF;
      4'hC: return 4'h8;  4'hD: return 4'h5;  4'hE: return 4'h3;  default: return 4'h6;
    endcase
  endfunction

  function automatic logic [127:0] model_f(input logic [127:0] k, input logic [4:0] c);
    logic [127:0] s;
    logic [127:0] r;
    s = {k[66:0], k[127:67]};
    r = s;
    r[127:124] = tb_sbox(s[127:124]);
    r[123:120] = tb_sbox(s[123:120]);
    r[66:62]   = s[66:62] ^ c;
    return r;
  endfunction

  task automatic fill_exp(input logic [127:0] key);
    logic [127:0] k;
    k = key;
    for (int i = 0; i < 26; i++) begin
      exp_rk[i] = k[63:0];
      if (i < 25) k = model_f(k, 5'(i + 1));
    end
  endtask

  task automatic start_pulse(input logic [127:0] key);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    key_in = ~key;
  endtask

  task automatic wait_idx(input logic [4:0] target);
    int c;
    c = 0;
    rk_ready = 1'b1;
    while (!(rk_valid && rk_idx == target) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("wait_idx_timeout", 128'(c < 100), 128'd1);
  endtask

  task automatic drain(input bit rnd, output int hs, output int dn, output int errs);
    bit          stall;
    bit          fin;
    bit          rdy;
    logic [63:0] p_rk;
    logic [4:0]  p_idx;
    hs = 0; dn = 0; errs = 0; stall = 0; fin = 0; p_rk = '0; p_idx = '0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (done) begin
        dn++;
        rk_ready = 1'b0;
        @(negedge clk);
        if (done) dn++;
        fin = 1;
      end else begin
        if (stall && (rk !== p_rk || rk_idx !== p_idx)) errs++;
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        rk_ready = rdy;
        if (rk_valid && rdy) begin
          if (rk_idx < 26) begin
            cap_rk[rk_idx] = rk;
            if (rk !== exp_rk[rk_idx]) errs++;
          end else begin
            errs++;
          end
          hs++;
        end
        stall = rk_valid && !rdy;
        p_rk  = rk;
        p_idx = rk_idx;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_full(input logic [127:0] key, input bit rnd);
    int hs, dn, errs;
    fill_exp(key);
    rk_ready = 1'b0;
    start_pulse(key);
    chk("load_valid", 128'(rk_valid), 128'd0);
    chk("load_busy", 128'(busy), 128'd1);
    drain(rnd, hs, dn, errs);
    chk("handshakes", 128'(hs), 128'd26);
    chk("done_pulses", 128'(dn), 128'd1);
    chk("rk_errors", 128'(errs), 128'd0);
    chk("end_idle", 128'({busy, rk_valid}), 128'd0);
  endtask

  initial begin
    int hs, dn, errs;
    logic [127:0] rkey;

    vecs[0] = '{"k0_rk0",   128'h0, 0, 64'h0000_0000_0000_0000};
    vecs[1] = '{"k0_rk1",   128'h0, 1, 64'h4000_0000_0000_0000};
    vecs[2] = '{"k0_rk2",   128'h0, 2, 64'h9DC0_0000_0000_0000};
    vecs[3] = '{"k1s_rk0",  {128{1'b1}}, 0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{"k1s_rk1",  {128{1'b1}}, 1, 64'hBFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{"kmix_rk0", 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 64'hFEDC_BA98_7654_3210};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({rk_valid, busy, done, rk_idx, rk}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 128'({rk_valid, busy, done, rk_idx, rk}), 128'd0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_idle", 128'({busy, rk_valid, done}), 128'd0);

    for (int v = 0; v < 6; v++) begin
      run_full(vecs[v].key, 1'b0);
      chk(vecs[v].name, 128'(cap_rk[vecs[v].idx]), 128'(vecs[v].rk));
    end

    run_full(128'h0, 1'b1);

    // abort on the idx 10 handshake
    fill_exp(128'h0);
    start_pulse(128'h0);
    wait_idx(5'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    rk_ready = 1'b0;
    chk("abort_valid", 128'({rk_valid, busy}), 128'd0);
    chk("abort_key_kept", 128'(rk), 128'(exp_rk[10]));
    dn = 0;
    repeat (3) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", 128'(dn), 128'd0);
    rk_ready = 1'b1;
    start_pulse(128'h0);
    @(negedge clk);
    chk("restart_latency", 128'(rk_valid), 128'd1);
    chk("restart_rk0", 128'({rk_idx, rk}), 128'd0);
    drain(1'b0, hs, dn, errs);
    chk("restart_hs", 128'(hs), 128'd26);
    chk("restart_done", 128'(dn), 128'd1);

    // start pulse ignored during RUN
    fill_exp(128'h0);
    start_pulse(128'h0);
    wait_idx(5'd5);
    key_in = {128{1'b1}};
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("ign_start_idx", 128'(rk_idx), 128'd6);
    chk("ign_start_rk6", 128'(rk), 128'(exp_rk[6]));
    drain(1'b0, hs, dn, errs);
    chk("ign_start_hs", 128'(hs), 128'd20);
    chk("ign_start_done", 128'(dn), 128'd1);
    chk("ign_start_errs", 128'(errs), 128'd0);

    // start and abort together in IDLE: start wins
    fill_exp(128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);
    key_in = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 128'(busy), 128'd1);
    drain(1'b0, hs, dn, errs);
    chk("start_abort_hs", 128'(hs), 128'd26);
    chk("start_abort_errs", 128'(errs), 128'd0);

    // asynchronous reset mid-schedule
    fill_exp(128'h0);
    start_pulse(128'h0);
    wait_idx(5'd12);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 128'({rk_valid, busy, done, rk_idx, rk}), 128'd0);
    @(negedge clk);
    chk("reset_no_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 128'({busy, rk_valid, done}), 128'd0);

    for (int r = 0; r < 1000; r++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_full(rkey, (r % 8) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
